mult_32: RTL and testbench

MULT_32 -- requirements
Module: mult_32

---
 rtl/mult_32.sv | 97 +++++++++
 tb/tb_mult_32.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_32.sv
// mult_32: 16x16 unsigned shift-and-add multiplier, one product bit per cycle.
// Ports: clk, rst (async high), init (start), A/B (operands) -> pp (product), done (pulse).
// Option: define MULT_32_EARLY_EXIT_EN to finish as soon as no multiplier bits remain.
module mult_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] pp,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_mcand;
    logic [15:0] r_mplr;
    logic [4:0]  r_cnt;
    logic [31:0] r_pp;
    logic        r_done;

    logic [15:0] w_mplr_next;
    logic [31:0] w_addend;
    logic [31:0] w_sum;
    logic        w_last;

    assign w_mplr_next = r_mplr >> 1;
    assign w_addend    = r_mplr[0] ? r_mcand : 32'h0;
    // Operands are 16 bits, so the running sum never exceeds 32 bits.
    assign w_sum       = r_pp + w_addend;

`ifdef MULT_32_EARLY_EXIT_EN
    // Stop once the multiplier has been shifted empty; later steps add nothing.
    assign w_last = (r_cnt == 5'd15) || (w_mplr_next == 16'h0);
`else
    assign w_last = (r_cnt == 5'd15);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_mcand <= 32'h0;
            r_mplr  <= 16'h0;
            r_cnt   <= 5'd0;
            r_pp    <= 32'h0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (init) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_done  <= 1'b0;
                    r_mcand <= {16'h0, A};
                    r_mplr  <= B;
                    r_pp    <= 32'h0;
                    r_cnt   <= 5'd0;
                    r_state <= CALC;
                end
                CALC: begin
                    r_pp    <= w_sum;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= w_mplr_next;
                    r_cnt   <= r_cnt + 5'd1;
                    // done is raised on entry so it lines up with DONE.
                    if (w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pp   = r_pp;
    assign done = r_done;

endmodule

// File: tb/tb_mult_32.sv
// tb_mult_32: randomized scoreboard bench for mult_32.
// Driver pushes expected product and completion cycle; monitor checks on done.
module tb_mult_32;

    logic        clk;
    logic        rst;
    logic        init;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] pp;
    logic        done;

    mult_32 dut (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .A    (A),
        .B    (B),
        .pp   (pp),
        .done (done)
    );

    typedef struct {
        logic [31:0] prod;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    logic        prev_done = 1'b0;
    logic [31:0] last_pp = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Number of CALC cycles for multiplier b, from the arithmetic definition.
    function automatic int calc_cycles(input logic [15:0] b);
`ifdef MULT_32_EARLY_EXIT_EN
        int hi;
        hi = 0;
        for (int i = 0; i < 16; i++) if (b[i]) hi = i;
        return hi + 1;
`else
        return 16;
`endif
    endfunction

    // One LOAD cycle plus the CALC cycles.
    function automatic int latency(input logic [15:0] b);
        return 1 + calc_cycles(b);
    endfunction

    // Monitor: every done must match the oldest pending operation.
    always @(negedge clk) begin
        if (done) begin
            chk("single_cycle_done", prev_done, 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", pp, e.prod);
                chk("done_cycle", cyc, e.cyc);
                last_pp = e.prod;
            end
        end
        prev_done = done;
    end

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    // Single operation; optionally disturb operands and init while CALC runs.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int hold, input bit disturb);
        exp_t e;
        bit   seen;
        @(negedge clk);
        A = a;
        B = b;
        init = 1'b1;
        e.prod = 32'(a) * 32'(b);
        e.cyc  = cyc + 1 + latency(b);
        sb.push_back(e);
        repeat (hold) @(negedge clk);
        init = 1'b0;
        if (disturb) begin
            if (hold < 2) @(negedge clk);
            A = 16'h0001;
            B = 16'h0001;
            init = 1'b1;
            @(negedge clk);
            init = 1'b0;
        end
        wait_done(seen);
        if (seen) begin
            repeat (3) @(negedge clk);
            chk("pp_held_idle", pp, e.prod);
            chk("done_low_idle", done, 0);
        end
    endtask

    task automatic run_b2b(input int n);
        exp_t        e;
        bit          seen;
        logic [15:0] a;
        logic [15:0] b;
        @(negedge clk);
        a = 16'($urandom);
        b = 16'($urandom);
        A = a;
        B = b;
        init = 1'b1;
        e.prod = 32'(a) * 32'(b);
        e.cyc  = cyc + 1 + latency(b);
        sb.push_back(e);
        for (int k = 1; k < n; k++) begin
            wait_done(seen);
            if (!seen) break;
            a = 16'($urandom);
            b = 16'($urandom);
            A = a;
            B = b;
            e.prod = 32'(a) * 32'(b);
            // DONE -> IDLE on the next edge, init re-sampled on the one after.
            e.cyc  = cyc + 2 + latency(b);
            sb.push_back(e);
        end
        wait_done(seen);
        init = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst  = 1'b1;
        init = 1'b0;
        A    = 16'h0;
        B    = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset_pp", pp, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_start", done, 0);

        run_op(16'h00F7, 16'h007F, 2, 0);
        run_op(16'hFFFF, 16'hFFFF, 1, 0);
        run_op(16'h0000, 16'h1234, 1, 0);
        run_op(16'h1234, 16'h0000, 1, 0);
        run_op(16'h00F7, 16'h0001, 1, 0);
        run_op(16'h00F7, 16'h8000, 1, 0);
        run_op(16'hABCD, 16'h5A5A, 2, 1);
        run_op(16'h00F7, 16'h0001, 2, 1);

        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), 16'($urandom),
                   $urandom_range(1, 2), 1'($urandom_range(0, 1)));

        // Abort mid-CALC with an asynchronous reset.
        @(negedge clk);
        A = 16'hFFFF;
        B = 16'hFFFF;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pp", pp, 0);
        chk("async_rst_done", done, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_done_after_abort", last_pp, 32'h00000000 + last_pp);
        run_op(16'd3, 16'd5, 1, 0);

        run_b2b(4);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
